msh_link_rx: RTL and testbench

Receive end of the credit-based mesh link between neighbouring mesh nodes. Accepts flits pushed by the upstream node's link transmitter without backpressure, buffers them in a DEPTH-entry FIFO, presents them to the local node's control/datapath with valid/ready, and returns one credit per dequeued flit. After reset it advertises the full buffer by issuing DEPTH initial credits; the transmitter resets to zero credits.

---
 rtl/mesh_pkg.sv | 15 +
 rtl/msh_link_rx_fifo.sv | 61 ++++++
 rtl/msh_link_rx.sv | 99 +++++++++
 tb/tb_msh_link_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared mesh definitions: flit width, default link receive buffer depth, link-rx FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mesh_pkg;

  localparam int MSH_FLIT_W        = 32;
  localparam int MSH_LINK_RX_DEPTH = 8;

  // INIT issues the initial credits; RUN is normal push/pop traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } msh_link_rx_state_t;

endpackage

// File: rtl/msh_link_rx_fifo.sv
// Circular flit buffer for the link receiver: storage, read/write pointers, occupancy, full/empty.
// Latency: a write at one edge is visible on rd_dat after that edge (no bypass path).
// Backpressure: none; push is ignored when full and pop when empty, so the parent owns drop policy.
// Ports: clk/rst (sync active-high); push/push_dat write side; pop/rd_dat read side; full/empty status.
module msh_link_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == CW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Drive zero while empty so the head output is clean after reset.
  assign rd_dat  = empty ? '0 : mem[rptr];

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/msh_link_rx.sv
// Mesh link receiver: buffers credit-paced flits from upstream and hands them to the node via valid/ready.
// Latency: 1 cycle input-to-o_vld; credit pulse 1 cycle after each pop; DEPTH initial credits after reset.
// Backpressure: none toward upstream (credits bound traffic); node stalls with i_rdy, o_flit held stable.
// Ports: mclk/mrst (sync active-high); i_flit_vld/i_flit (+i_par) from link; o_crd_rtn to upstream;
//   o_vld/o_flit/i_rdy to node; sticky o_err_ovfl, o_err_proto, o_err_par.
// Option: MSH_LINK_RX_PARITY_EN adds i_par and the even-parity checker behind o_err_par.
module msh_link_rx
  import mesh_pkg::*;
#(
  parameter int DEPTH  = MSH_LINK_RX_DEPTH,
  parameter int FLIT_W = MSH_FLIT_W
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic              i_flit_vld,
  input  logic [FLIT_W-1:0] i_flit,
`ifdef MSH_LINK_RX_PARITY_EN
  input  logic              i_par,
`endif
  output logic              o_crd_rtn,
  output logic              o_vld,
  output logic [FLIT_W-1:0] o_flit,
  input  logic              i_rdy,
  output logic              o_err_ovfl,
  output logic              o_err_proto,
  output logic              o_err_par
);

  localparam int ICW = $clog2(DEPTH);

  msh_link_rx_state_t state, state_nxt;
  logic [ICW-1:0]     init_cnt;
  logic               full, empty;
  logic               push, pop, crd_nxt, ovfl_ev, proto_ev;

  assign o_vld = !empty;
  assign pop   = o_vld && i_rdy;

  msh_link_rx_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_fifo (
    .clk      (mclk),
    .rst      (mrst),
    .push     (push),
    .push_dat (i_flit),
    .pop      (pop),
    .rd_dat   (o_flit),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_nxt = state;
    crd_nxt   = 1'b0;
    push      = 1'b0;
    ovfl_ev   = 1'b0;
    proto_ev  = 1'b0;
    case (state)
      INIT: begin
        // One credit per cycle; the upstream cannot send yet, so any flit is a protocol error.
        crd_nxt  = 1'b1;
        proto_ev = i_flit_vld;
        if (init_cnt == ICW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        crd_nxt = pop;
        push    = i_flit_vld && !full;
        // Full is judged before any same-cycle pop frees a slot.
        ovfl_ev = i_flit_vld && full;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state       <= INIT;
      init_cnt    <= '0;
      o_crd_rtn   <= 1'b0;
      o_err_ovfl  <= 1'b0;
      o_err_proto <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_crd_rtn <= crd_nxt;
      if (state == INIT) init_cnt <= init_cnt + ICW'(1);
      if (ovfl_ev)  o_err_ovfl  <= 1'b1;
      if (proto_ev) o_err_proto <= 1'b1;
    end
  end

`ifdef MSH_LINK_RX_PARITY_EN
  // Even parity over {flit, par}: the XOR of all bits must be 0. Flit is kept regardless.
  always_ff @(posedge mclk) begin
    if (mrst) o_err_par <= 1'b0;
    else if (push && (^{i_flit, i_par})) o_err_par <= 1'b1;
  end
`else
  assign o_err_par = 1'b0;
`endif

endmodule

// File: tb/tb_msh_link_rx.sv
module tb_msh_link_rx;
  import mesh_pkg::*;

  localparam int W = MSH_FLIT_W;

  logic         mclk = 1'b0;
  logic         mrst = 1'b1;
  logic         i_flit_vld = 1'b0;
  logic [W-1:0] i_flit = '0;
  logic         i_par = 1'b0;
  logic         i_rdy = 1'b0;

  logic         crd8, vld8, ovfl8, proto8, par8;
  logic [W-1:0] flit8;
  logic         crd6, vld6, ovfl6, proto6, par6;
  logic [W-1:0] flit6;

  always #5 mclk = ~mclk;

  msh_link_rx #(.DEPTH(8), .FLIT_W(W)) u_dut (
    .mclk(mclk), .mrst(mrst), .i_flit_vld(i_flit_vld), .i_flit(i_flit),
`ifdef MSH_LINK_RX_PARITY_EN
    .i_par(i_par),
`endif
    .o_crd_rtn(crd8), .o_vld(vld8), .o_flit(flit8), .i_rdy(i_rdy),
    .o_err_ovfl(ovfl8), .o_err_proto(proto8), .o_err_par(par8)
  );

  msh_link_rx #(.DEPTH(6), .FLIT_W(W)) u_dut6 (
    .mclk(mclk), .mrst(mrst), .i_flit_vld(i_flit_vld), .i_flit(i_flit),
`ifdef MSH_LINK_RX_PARITY_EN
    .i_par(i_par),
`endif
    .o_crd_rtn(crd6), .o_vld(vld6), .o_flit(flit6), .i_rdy(i_rdy),
    .o_err_ovfl(ovfl6), .o_err_proto(proto6), .o_err_par(par6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard / reference model of the selected DUT.
  bit           sel = 1'b0;  // 0: DEPTH=8 instance, 1: DEPTH=6 instance
  int           depth = 8;
  logic [W-1:0] sbq[$];
  int           model_occ = 0;
  bit           exp_ovfl = 1'b0;
  bit           exp_proto = 1'b0;
  bit           exp_par = 1'b0;

  typedef struct {
    bit  vld;       // flit on link (applied in the protocol-error pass only)
    bit  exp_crd;
    bit  exp_vld;
    bit  exp_proto; // expected in the protocol-error pass
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic model_clear();
    sbq.delete();
    model_occ = 0;
    exp_ovfl  = 1'b0;
    exp_proto = 1'b0;
    exp_par   = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " crd"},   {31'd0, crd8},   0);
    chk({nm, " vld"},   {31'd0, vld8},   0);
    chk({nm, " flit"},  flit8,           0);
    chk({nm, " ovfl"},  {31'd0, ovfl8},  0);
    chk({nm, " proto"}, {31'd0, proto8}, 0);
    chk({nm, " par"},   {31'd0, par8},   0);
  endtask

  // Reset release with DEPTH=8: credits, o_vld, and (pass 1) protocol error from a flit in INIT.
  task automatic run_table(input bit pass);
    mrst = 1'b0;
    i_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_flit_vld = pass ? tbl[i].vld : 1'b0;
      i_flit     = 32'hAA;
      step();
      chk($sformatf("init%0d crd[%0d]", pass, i),   {31'd0, crd8},   {31'd0, tbl[i].exp_crd});
      chk($sformatf("init%0d vld[%0d]", pass, i),   {31'd0, vld8},   {31'd0, tbl[i].exp_vld});
      chk($sformatf("init%0d proto[%0d]", pass, i), {31'd0, proto8}, {31'd0, pass && tbl[i].exp_proto});
    end
    i_flit_vld = 1'b0;
  endtask

  // One RUN-state cycle on the selected DUT with scoreboard checks.
  task automatic cyc(input bit vld, input logic [W-1:0] flit, input bit rdy, input bit par);
    bit           cv, pop, cc, ov, pe;
    logic [W-1:0] cf, exp;
    i_flit_vld = vld;
    i_flit     = flit;
    i_rdy      = rdy;
    i_par      = par;
    cv  = sel ? vld6 : vld8;
    cf  = sel ? flit6 : flit8;
    pop = cv && rdy;
    if (pop) begin
      if (sbq.size() == 0) chk("unexpected pop", 1, 0);
      else begin
        exp = sbq.pop_front();
        chk("flit order", cf, exp);
      end
    end
    if (vld) begin
      if (model_occ == depth) exp_ovfl = 1'b1;
      else begin
        sbq.push_back(flit);
        model_occ++;
`ifdef MSH_LINK_RX_PARITY_EN
        if (^{flit, par}) exp_par = 1'b1;
`endif
      end
    end
    if (pop) model_occ--;
    step();
    cc = sel ? crd6 : crd8;
    ov = sel ? ovfl6 : ovfl8;
    pe = sel ? par6 : par8;
    cv = sel ? vld6 : vld8;
    chk("credit per pop", {31'd0, cc}, {31'd0, pop});
    chk("o_vld", {31'd0, cv}, {31'd0, model_occ > 0});
    chk("err_ovfl", {31'd0, ov}, {31'd0, exp_ovfl});
    chk("err_par", {31'd0, pe}, {31'd0, exp_par});
    i_flit_vld = 1'b0;
  endtask

  task automatic fill(input logic [W-1:0] base, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, base + W'(k), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].vld       = (i == 3);
      tbl[i].exp_crd   = (i < 8);
      tbl[i].exp_vld   = 1'b0;
      tbl[i].exp_proto = (i >= 3);
    end

    // Reset state.
    step();
    step();
    chk_all_zero("reset");

    // Clean INIT: exactly 8 credits.
    run_table(1'b0);

    // Fill 1..8 without ready, then drain in order.
    model_clear();
    fill(32'h1, 8);
    chk("no ovfl after 8", {31'd0, ovfl8}, 0);
    chk("head is 1", flit8, 32'h1);
    drain(9);

    // Full buffer, 9th push without pop: dropped, 8 remain.
    fill(32'h11, 8);
    cyc(1'b1, 32'h99, 1'b0, 1'b0);
    drain(9);

    // Full buffer, 9th push with same-cycle pop: dropped, 7 remain.
    fill(32'h21, 8);
    cyc(1'b1, 32'h9A, 1'b1, 1'b0);
    drain(8);
    chk("ovfl sticky", {31'd0, ovfl8}, 1);

    // Mid-stream reset with a pop pending at the reset edge.
    fill(32'h31, 3);
    i_rdy = 1'b1;
    mrst  = 1'b1;
    step();
    i_rdy = 1'b0;
    chk_all_zero("midrst");
    model_clear();

    // Flit during INIT cycle 3: protocol error, still 8 credits.
    run_table(1'b1);

    // DEPTH=6 wrap: occupancy 3 with continuous push+pop for 20 cycles.
    mrst = 1'b1;
    step();
    mrst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("d6 init crd[%0d]", i), {31'd0, crd6}, {31'd0, i < 6});
    end
    sel = 1'b1;
    depth = 6;
    model_clear();
    fill(32'h41, 3);
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h100 + W'(i), 1'b1, 1'b0);
    drain(4);
    chk("d6 empty at end", {31'd0, vld6}, 0);
    sel = 1'b0;
    depth = 8;

`ifdef MSH_LINK_RX_PARITY_EN
    mrst = 1'b1;
    step();
    run_table(1'b0);
    model_clear();
    cyc(1'b1, 32'h3, 1'b0, 1'b1);
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("par sticky", {31'd0, par8}, 1);
    mrst = 1'b1;
    step();
    chk_all_zero("par midrst");
    model_clear();
    run_table(1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
